// File: rtl/instruction_memory_loadable_pkg.sv
// Shared IF/decode definitions: NOP encoding, instruction field layout, fetch FSM states.
package instruction_memory_loadable_pkg;

  localparam int          DEFAULT_DATA_W = 32;
  localparam logic [31:0] NOP_ENC        = 32'h0000_0000;

  // Field layout: [31:28] opcode, [27:22] rd, [21:16] rs, [15:10] rt, [9:0] unused
  localparam int OPC_W    = 4;
  localparam int REG_W    = 6;
  localparam int UNUSED_W = 10;
  localparam int OPC_LSB  = 28;
  localparam int RD_LSB   = 22;
  localparam int RS_LSB   = 16;
  localparam int RT_LSB   = 10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } imem_state_e;

  function automatic logic [31:0] make_instr(input logic [OPC_W-1:0] opc,
                                             input logic [REG_W-1:0] rd,
                                             input logic [REG_W-1:0] rs,
                                             input logic [REG_W-1:0] rt);
    return {opc, rd, rs, rt, {UNUSED_W{1'b0}}};
  endfunction

endpackage

// File: rtl/instruction_memory_loadable.sv
// IF-stage instruction store with runtime program load, post-reset NOP sweep,
// stall/flush control and an address-fault qualifier on the registered fetch.
module instruction_memory_loadable
  import instruction_memory_loadable_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter int                DEPTH     = 256,
  parameter bit                BYTE_ADDR = 1'b0,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_ENC)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       fetch_addr,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic              load_en,
  input  logic [31:0]       load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] instr_out,
  output logic              addr_fault,
  output logic              ready
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  function automatic logic [31:0] word_index(input logic [31:0] a);
    return BYTE_ADDR ? {2'b00, a[31:2]} : a;
  endfunction

  function automatic logic addr_valid(input logic [31:0] a, input logic [31:0] w);
    logic misaligned;
    misaligned = BYTE_ADDR && (a[1:0] != 2'b00);
    return !misaligned && (w < 32'(DEPTH));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  imem_state_e       state;
  logic [IDX_W-1:0]  clr_cnt;

  logic [31:0]       fetch_word;
  logic [31:0]       load_word;
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  load_idx;
  logic              fetch_ok;
  logic              load_ok;

  assign fetch_word = word_index(fetch_addr);
  assign load_word  = word_index(load_addr);
  assign fetch_idx  = fetch_word[IDX_W-1:0];
  assign load_idx   = load_word[IDX_W-1:0];
  assign fetch_ok   = addr_valid(fetch_addr, fetch_word);
  assign load_ok    = addr_valid(load_addr, load_word);

  // Single write port: the sweep owns it during CLEAR, the loader afterwards.
  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = load_idx;
    mem_wd = load_data;
    if (state == ST_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_cnt;
      mem_wd = NOP_WORD;
    end else if (load_en && load_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Read is registered alongside the write, so a same-edge load returns the old word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      ready      <= 1'b0;
      instr_out  <= NOP_WORD;
      addr_fault <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (flush) begin
            instr_out  <= NOP_WORD;
            addr_fault <= 1'b0;
          end else if (fetch_en) begin
            if (fetch_ok) begin
              instr_out  <= mem[fetch_idx];
              addr_fault <= 1'b0;
            end else begin
              instr_out  <= NOP_WORD;
              addr_fault <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Bench for the loadable instruction memory: word-addressed 256-deep and byte-addressed 16-deep copies.
module tb_instruction_memory_loadable;

  localparam int DW      = 32;
  localparam int DEPTH_A = 256;
  localparam int DEPTH_B = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  logic [31:0] fa_a, la_a, ld_a, io_a;
  logic        fe_a, fl_a, le_a, af_a, rdy_a;
  logic [31:0] fa_b, la_b, ld_b, io_b;
  logic        fe_b, fl_b, le_b, af_b, rdy_b;

  instruction_memory_loadable #(.DATA_W(DW), .DEPTH(DEPTH_A), .BYTE_ADDR(1'b0)) dut_a (
    .clock(clock), .reset_n(reset_n), .fetch_addr(fa_a), .fetch_en(fe_a), .flush(fl_a),
    .load_en(le_a), .load_addr(la_a), .load_data(ld_a),
    .instr_out(io_a), .addr_fault(af_a), .ready(rdy_a)
  );

  instruction_memory_loadable #(.DATA_W(DW), .DEPTH(DEPTH_B), .BYTE_ADDR(1'b1)) dut_b (
    .clock(clock), .reset_n(reset_n), .fetch_addr(fa_b), .fetch_en(fe_b), .flush(fl_b),
    .load_en(le_b), .load_addr(la_b), .load_data(ld_b),
    .instr_out(io_b), .addr_fault(af_b), .ready(rdy_b)
  );

  typedef struct {
    logic        fe;
    logic        fl;
    logic        le;
    logic [31:0] fa;
    logic [31:0] la;
    logic [31:0] ld;
    logic [31:0] exp_instr;
    logic        exp_fault;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model for the word-addressed copy
  logic [31:0] model_a [DEPTH_A];
  logic [31:0] prev_instr;
  logic        prev_fault;

  vec_t tab_a [21];
  vec_t tab_b [12];
  vec_t rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fe_a = 0; fl_a = 0; le_a = 0; fa_a = 0; la_a = 0; ld_a = 0;
    fe_b = 0; fl_b = 0; le_b = 0; fa_b = 0; la_b = 0; ld_b = 0;
  endtask

  task automatic apply_vec(input vec_t v, input bit on_b, input string tag);
    @(negedge clock);
    idle_inputs();
    if (!on_b) begin
      fe_a = v.fe; fl_a = v.fl; le_a = v.le; fa_a = v.fa; la_a = v.la; ld_a = v.ld;
    end else begin
      fe_b = v.fe; fl_b = v.fl; le_b = v.le; fa_b = v.fa; la_b = v.la; ld_b = v.ld;
    end
    @(posedge clock);
    #1;
    if (!on_b) begin
      check({tag, ".instr"}, io_a, v.exp_instr);
      check({tag, ".fault"}, {31'b0, af_a}, {31'b0, v.exp_fault});
      if (v.le && v.la < DEPTH_A) model_a[v.la] = v.ld;
      prev_instr = v.exp_instr;
      prev_fault = v.exp_fault;
    end else begin
      check({tag, ".instr"}, io_b, v.exp_instr);
      check({tag, ".fault"}, {31'b0, af_b}, {31'b0, v.exp_fault});
    end
  endtask

  task automatic sweep_wait(input string tag);
    for (int i = 1; i <= DEPTH_A; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("%s.ready@%0d", tag, i), {31'b0, rdy_a}, (i == DEPTH_A) ? 32'd1 : 32'd0);
      if (i == 128) check({tag, ".clr_instr"}, io_a, 32'h0);
      if (i == DEPTH_B) check({tag, ".b_ready"}, {31'b0, rdy_b}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            fe fl le  fa            la            ld             exp_instr      flt
    tab_a[0]  = '{1, 0, 0, 32'd5,   32'd0,   32'h0,         32'h0,         0};
    tab_a[1]  = '{0, 0, 1, 32'd0,   32'd3,   32'h5140_0400, 32'h0,         0};
    tab_a[2]  = '{1, 0, 0, 32'd3,   32'd0,   32'h0,         32'h5140_0400, 0};
    tab_a[3]  = '{1, 0, 1, 32'd7,   32'd7,   32'hE284_0000, 32'h0,         0};
    tab_a[4]  = '{1, 0, 0, 32'd7,   32'd0,   32'h0,         32'hE284_0000, 0};
    tab_a[5]  = '{1, 0, 0, 32'd3,   32'd0,   32'h0,         32'h5140_0400, 0};
    tab_a[6]  = '{0, 0, 0, 32'd7,   32'd0,   32'h0,         32'h5140_0400, 0};
    tab_a[7]  = '{0, 0, 0, 32'd256, 32'd0,   32'h0,         32'h5140_0400, 0};
    tab_a[8]  = '{0, 0, 0, 32'd1,   32'd0,   32'h0,         32'h5140_0400, 0};
    tab_a[9]  = '{1, 1, 0, 32'd7,   32'd0,   32'h0,         32'h0,         0};
    tab_a[10] = '{1, 0, 0, 32'd256, 32'd0,   32'h0,         32'h0,         1};
    tab_a[11] = '{0, 0, 0, 32'd3,   32'd0,   32'h0,         32'h0,         1};
    tab_a[12] = '{1, 0, 0, 32'd255, 32'd0,   32'h0,         32'h0,         0};
    tab_a[13] = '{1, 0, 1, 32'd10,  32'd300, 32'hFFFF_FFFF, 32'h0,         0};
    tab_a[14] = '{1, 0, 0, 32'd256, 32'd0,   32'h0,         32'h0,         1};
    tab_a[15] = '{0, 1, 0, 32'd3,   32'd0,   32'h0,         32'h0,         0};
    tab_a[16] = '{0, 0, 1, 32'd0,   32'd255, 32'h1234_5678, 32'h0,         0};
    tab_a[17] = '{1, 0, 0, 32'd255, 32'd0,   32'h0,         32'h1234_5678, 0};
    tab_a[18] = '{1, 1, 1, 32'd3,   32'd20,  32'hAAAA_5555, 32'h0,         0};
    tab_a[19] = '{1, 0, 0, 32'd20,  32'd0,   32'h0,         32'hAAAA_5555, 0};
    tab_a[20] = '{1, 0, 0, 32'd44,  32'd0,   32'h0,         32'h0,         0};

    tab_b[0]  = '{0, 0, 1, 32'h00, 32'h0C, 32'h5140_0400, 32'h0,         0};
    tab_b[1]  = '{1, 0, 0, 32'h0C, 32'h00, 32'h0,         32'h5140_0400, 0};
    tab_b[2]  = '{1, 0, 0, 32'h0D, 32'h00, 32'h0,         32'h0,         1};
    tab_b[3]  = '{0, 0, 1, 32'h00, 32'h0D, 32'hFFFF_FFFF, 32'h0,         1};
    tab_b[4]  = '{1, 0, 0, 32'h0C, 32'h00, 32'h0,         32'h5140_0400, 0};
    tab_b[5]  = '{1, 0, 0, 32'h40, 32'h00, 32'h0,         32'h0,         1};
    tab_b[6]  = '{1, 0, 0, 32'h3C, 32'h00, 32'h0,         32'h0,         0};
    tab_b[7]  = '{0, 0, 1, 32'h00, 32'h40, 32'hDEAD_0001, 32'h0,         0};
    tab_b[8]  = '{1, 0, 0, 32'h00, 32'h00, 32'h0,         32'h0,         0};
    tab_b[9]  = '{0, 0, 1, 32'h00, 32'h3C, 32'hCAFE_F00D, 32'h0,         0};
    tab_b[10] = '{1, 0, 0, 32'h3C, 32'h00, 32'h0,         32'hCAFE_F00D, 0};
    tab_b[11] = '{1, 0, 0, 32'h0E, 32'h00, 32'h0,         32'h0,         1};

    for (int i = 0; i < DEPTH_A; i++) model_a[i] = 32'h0;
    prev_instr = 32'h0;
    prev_fault = 1'b0;

    // Reset state, with loader and fetch already active (must be ignored during the sweep)
    idle_inputs();
    reset_n = 1'b0;
    fe_a = 1; fa_a = 32'd10; le_a = 1; la_a = 32'd10; ld_a = 32'hDEAD_BEEF;
    #2;
    check("rst.instr", io_a, 32'h0);
    check("rst.fault", {31'b0, af_a}, 32'h0);
    check("rst.ready", {31'b0, rdy_a}, 32'h0);
    check("rst.b_ready", {31'b0, rdy_b}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    sweep_wait("sweep1");

    for (int i = 0; i < 21; i++) apply_vec(tab_a[i], 1'b0, $sformatf("tab_a[%0d]", i));
    for (int i = 0; i < 12; i++) apply_vec(tab_b[i], 1'b1, $sformatf("tab_b[%0d]", i));

    // Randomised traffic; loads stay above idx 31 so idx 3 and 7 keep their words
    for (int n = 0; n < 400; n++) begin
      rv.fe = 1'($urandom_range(0, 1));
      rv.fl = ($urandom_range(0, 7) == 0);
      rv.le = 1'($urandom_range(0, 1));
      rv.fa = $urandom_range(0, 299);
      rv.la = $urandom_range(32, 299);
      rv.ld = $urandom;
      if (rv.fl) begin
        rv.exp_instr = 32'h0; rv.exp_fault = 1'b0;
      end else if (rv.fe) begin
        if (rv.fa < DEPTH_A) begin
          rv.exp_instr = model_a[rv.fa]; rv.exp_fault = 1'b0;
        end else begin
          rv.exp_instr = 32'h0; rv.exp_fault = 1'b1;
        end
      end else begin
        rv.exp_instr = prev_instr; rv.exp_fault = prev_fault;
      end
      apply_vec(rv, 1'b0, "rand");
    end

    // Asynchronous reset mid-RUN, then a full re-sweep wipes loaded words
    rv = '{1, 0, 0, 32'd3, 32'd0, 32'h0, 32'h5140_0400, 0};
    apply_vec(rv, 1'b0, "pre_rst");
    @(negedge clock);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst.instr", io_a, 32'h0);
    check("async_rst.ready", {31'b0, rdy_a}, 32'h0);
    check("async_rst.fault", {31'b0, af_a}, 32'h0);
    check("async_rst.b_ready", {31'b0, rdy_b}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH_A; i++) model_a[i] = 32'h0;
    sweep_wait("sweep2");

    rv = '{1, 0, 0, 32'd3,   32'd0, 32'h0, 32'h0, 0};
    apply_vec(rv, 1'b0, "wiped3");
    rv = '{1, 0, 0, 32'd7,   32'd0, 32'h0, 32'h0, 0};
    apply_vec(rv, 1'b0, "wiped7");
    rv = '{1, 0, 0, 32'd255, 32'd0, 32'h0, 32'h0, 0};
    apply_vec(rv, 1'b0, "wiped255");
    rv = '{1, 0, 0, 32'h0C,  32'd0, 32'h0, 32'h0, 0};
    apply_vec(rv, 1'b1, "wiped_b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
